alu_result_buffer: RTL and testbench

Parametrised ALU result register for the 16-bit RISC datapath. It replaces the single-word ALU output latch with a DEPTH-entry result queue. Each entry holds the ALU result, its status flags and its destination register, and the queue drains to writeback under a valid/ready handshake. A separate forwarding register always holds the most recently accepted result for operand bypass, and a flush input discards queued results on a branch or exception.

---
 rtl/alu_result_buffer.sv | 93 +++++++++
 tb/tb_alu_result_buffer.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/alu_result_buffer.sv
// alu_result_buffer: DEPTH-entry ALU result queue with valid/ready drain, forwarding register and flush.
//   clk, reset (sync, active-low)
//   in_valid/in_ready/in_data/in_flags/in_rd : ALU result push side
//   flush                                    : discard queued entries, clear fwd_valid
//   out_valid/out_ready/out_data/out_flags/out_rd : head entry to writeback
//   count                                    : occupancy
//   fwd_valid/fwd_data/fwd_rd                : most recently accepted result for bypass
module alu_result_buffer #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 2,
    parameter int RD_W  = 3,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [3:0]       in_flags,
    input  logic [RD_W-1:0]  in_rd,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [3:0]       out_flags,
    output logic [RD_W-1:0]  out_rd,
    output logic [CNT_W-1:0] count,
    output logic             fwd_valid,
    output logic [WIDTH-1:0] fwd_data,
    output logic [RD_W-1:0]  fwd_rd
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

    logic [WIDTH-1:0] data_q  [DEPTH];
    logic [3:0]       flags_q [DEPTH];
    logic [RD_W-1:0]  rd_q    [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             fwd_valid_q, fwd_valid_d;
    logic [WIDTH-1:0] fwd_data_q, fwd_data_d;
    logic [RD_W-1:0]  fwd_rd_q, fwd_rd_d;
    logic             push, pop;

    assign out_valid = count_q != '0;
    assign in_ready  = (count_q != FULL) && reset;
    assign push      = in_valid && in_ready && !flush;
    assign pop       = out_valid && out_ready && !flush;
    assign count     = count_q;
    // Storage is never reset, so the head is masked while the queue is empty.
    assign out_data  = out_valid ? data_q[rd_ptr_q]  : '0;
    assign out_flags = out_valid ? flags_q[rd_ptr_q] : '0;
    assign out_rd    = out_valid ? rd_q[rd_ptr_q]    : '0;
    assign fwd_valid = fwd_valid_q;
    assign fwd_data  = fwd_data_q;
    assign fwd_rd    = fwd_rd_q;

    always_comb begin
        wr_ptr_d    = flush ? '0 : push ? ((wr_ptr_q == LAST) ? '0 : wr_ptr_q + 1'b1) : wr_ptr_q;
        rd_ptr_d    = flush ? '0 : pop ? ((rd_ptr_q == LAST) ? '0 : rd_ptr_q + 1'b1) : rd_ptr_q;
        count_d     = flush ? '0 : (push && !pop) ? count_q + 1'b1 : (pop && !push) ? count_q - 1'b1 : count_q;
        fwd_valid_d = !flush && (push || fwd_valid_q);
        fwd_data_d  = push ? in_data : fwd_data_q;
        fwd_rd_d    = push ? in_rd : fwd_rd_q;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            fwd_valid_q <= 1'b0;
            fwd_data_q  <= '0;
            fwd_rd_q    <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            fwd_valid_q <= fwd_valid_d;
            fwd_data_q  <= fwd_data_d;
            fwd_rd_q    <= fwd_rd_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            data_q[wr_ptr_q]  <= in_data;
            flags_q[wr_ptr_q] <= in_flags;
            rd_q[wr_ptr_q]    <= in_rd;
        end
    end
endmodule

// File: tb/tb_alu_result_buffer.sv
// tb_alu_result_buffer: drives DEPTH=2 and DEPTH=3 buffers in lockstep against a queue model.
module tb_alu_result_buffer;
    typedef struct packed {
        logic [15:0] d;
        logic [3:0]  f;
        logic [2:0]  r;
    } ent_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] in_data = '0;
    logic [3:0]  in_flags = '0;
    logic [2:0]  in_rd = '0;
    logic        flush = 1'b0;
    logic        out_ready = 1'b0;

    logic        in_ready [2];
    logic        out_valid [2];
    logic [15:0] out_data [2];
    logic [3:0]  out_flags [2];
    logic [2:0]  out_rd [2];
    logic [1:0]  count [2];
    logic        fwd_valid [2];
    logic [15:0] fwd_data [2];
    logic [2:0]  fwd_rd [2];

    ent_t        q [2][$];
    logic        fv [2];
    logic [15:0] fd [2];
    logic [2:0]  fr [2];
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    alu_result_buffer #(.WIDTH(16), .DEPTH(2), .RD_W(3)) u_d2 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready[0]),
        .in_data(in_data), .in_flags(in_flags), .in_rd(in_rd), .flush(flush),
        .out_valid(out_valid[0]), .out_ready(out_ready), .out_data(out_data[0]),
        .out_flags(out_flags[0]), .out_rd(out_rd[0]), .count(count[0]),
        .fwd_valid(fwd_valid[0]), .fwd_data(fwd_data[0]), .fwd_rd(fwd_rd[0])
    );

    alu_result_buffer #(.WIDTH(16), .DEPTH(3), .RD_W(3)) u_d3 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready[1]),
        .in_data(in_data), .in_flags(in_flags), .in_rd(in_rd), .flush(flush),
        .out_valid(out_valid[1]), .out_ready(out_ready), .out_data(out_data[1]),
        .out_flags(out_flags[1]), .out_rd(out_rd[1]), .count(count[1]),
        .fwd_valid(fwd_valid[1]), .fwd_data(fwd_data[1]), .fwd_rd(fwd_rd[1])
    );

    task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s depth=%0d: got %0h expected %0h", tag, k + 2, obs, exp);
        end
    endtask

    // One clock edge: model sees the inputs applied before the edge, outputs checked 1 time unit later.
    task automatic step();
        ent_t e;
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            int  n;
            bit  rdy;
            bit  vld;
            n   = q[k].size();
            rdy = (n < k + 2);
            vld = (n > 0);
            if (!reset) begin
                q[k].delete();
                fv[k] = 1'b0;
                fd[k] = '0;
                fr[k] = '0;
            end else if (flush) begin
                q[k].delete();
                fv[k] = 1'b0;
            end else begin
                if (vld && out_ready) void'(q[k].pop_front());
                if (rdy && in_valid) begin
                    e.d = in_data;
                    e.f = in_flags;
                    e.r = in_rd;
                    q[k].push_back(e);
                    fv[k] = 1'b1;
                    fd[k] = in_data;
                    fr[k] = in_rd;
                end
            end
        end
        #1;
        for (int k = 0; k < 2; k++) begin
            int n;
            n = q[k].size();
            chk("count", k, 32'(count[k]), 32'(n));
            chk("out_valid", k, 32'(out_valid[k]), 32'(n > 0));
            chk("in_ready", k, 32'(in_ready[k]), 32'(reset && (n < k + 2)));
            chk("out_data", k, 32'(out_data[k]), (n > 0) ? 32'(q[k][0].d) : 32'd0);
            chk("out_flags", k, 32'(out_flags[k]), (n > 0) ? 32'(q[k][0].f) : 32'd0);
            chk("out_rd", k, 32'(out_rd[k]), (n > 0) ? 32'(q[k][0].r) : 32'd0);
            chk("fwd_valid", k, 32'(fwd_valid[k]), 32'(fv[k]));
            chk("fwd_data", k, 32'(fwd_data[k]), 32'(fd[k]));
            chk("fwd_rd", k, 32'(fwd_rd[k]), 32'(fr[k]));
        end
    endtask

    task automatic drive(input logic v, input logic [15:0] d, input logic [2:0] r, input logic ordy, input logic fl);
        in_valid  = v;
        in_data   = d;
        in_flags  = 4'($urandom);
        in_rd     = r;
        out_ready = ordy;
        flush     = fl;
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            fv[k] = 1'b0;
            fd[k] = '0;
            fr[k] = '0;
        end
        // Reset held with a pending result: nothing may be accepted.
        reset = 1'b0;
        drive(1'b1, 16'hFFFF, 3'd7, 1'b0, 1'b0);
        repeat (3) step();
        reset = 1'b1;
        drive(1'b0, 16'h0, 3'd0, 1'b0, 1'b0);
        step();
        // Fill with writeback stalled, hold, then drain.
        drive(1'b1, 16'h1234, 3'd3, 1'b0, 1'b0);
        step();
        drive(1'b1, 16'hABCD, 3'd5, 1'b0, 1'b0);
        step();
        drive(1'b0, 16'h0, 3'd0, 1'b0, 1'b0);
        repeat (2) step();
        drive(1'b0, 16'h0, 3'd0, 1'b1, 1'b0);
        repeat (3) step();
        // Continuous stream with writeback always ready.
        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, 16'(i), 3'(i), 1'b1, 1'b0);
            step();
        end
        drive(1'b0, 16'h0, 3'd0, 1'b1, 1'b0);
        step();
        // Randomised traffic to exercise wrap on both depths.
        for (int i = 0; i < 60; i++) begin
            drive(1'($urandom), 16'($urandom), 3'($urandom), 1'($urandom), ($urandom_range(0, 15) == 0));
            step();
        end
        // Flush colliding with push and pop.
        drive(1'b0, 16'h0, 3'd0, 1'b1, 1'b1);
        step();
        drive(1'b1, 16'h1111, 3'd1, 1'b0, 1'b0);
        step();
        drive(1'b1, 16'h2222, 3'd2, 1'b0, 1'b0);
        step();
        drive(1'b1, 16'h3333, 3'd4, 1'b1, 1'b1);
        step();
        drive(1'b0, 16'h0, 3'd0, 1'b0, 1'b0);
        step();
        // Reset mid-stream, then a fresh push.
        drive(1'b1, 16'h5555, 3'd6, 1'b0, 1'b0);
        step();
        drive(1'b1, 16'h6666, 3'd2, 1'b0, 1'b0);
        step();
        reset = 1'b0;
        drive(1'b0, 16'h0, 3'd0, 1'b0, 1'b0);
        step();
        reset = 1'b1;
        drive(1'b1, 16'h0042, 3'd3, 1'b0, 1'b0);
        step();
        drive(1'b0, 16'h0, 3'd0, 1'b1, 1'b0);
        repeat (2) step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
